// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx_pkg
// Description : Shared definitions for the FIFO-fed UART transmitter.
//               Provides the data width, the 3-bit FSM state encoding and the
//               parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_uart_tx_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    // Even parity when odd_sel=0, odd parity when odd_sel=1.
    function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data,
                                         input logic                   odd_sel);
        return (^data) ^ odd_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_cnt
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//               wraps at each bit boundary; tick marks the last cycle of a bit.
// Ports       : clk_i   - system clock
//               rst_n_i - asynchronous active-low reset
//               clr     - synchronous clear (takes priority over en)
//               en      - count enable
//               tick    - high on the last cycle of each bit period
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == LAST_CNT);
    assign tick   = en & w_last;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : UART transmitter draining a synchronous FIFO read port.
//               Pops one byte per frame and sends start, 8 data bits LSB
//               first, optional parity and 1 or 2 stop bits.
// Ports       : clk_i        - system clock
//               rst_n_i      - asynchronous active-low reset
//               fifo_rdata_i - FIFO read data, valid the cycle after a pop
//               fifo_empty_i - FIFO empty flag
//               fifo_rd_en_o - single-cycle pop strobe
//               tx_en_i      - permits starting new frames
//               tx_o         - registered UART line, idles high
//               busy_o       - high whenever the FSM is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [UART_DATA_W-1:0] fifo_rdata_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_rd_en_o,
    input  logic                   tx_en_i,
    output logic                   tx_o,
    output logic                   busy_o
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] w_shift_next;
    logic [2:0]             r_bit_idx;
    logic                   r_parity;
    logic                   r_stop_idx;
    logic                   r_tx;
    logic                   w_tx_next;
    logic                   w_tick;
    logic                   w_baud_clr;
    logic                   w_baud_en;
    logic                   w_last_stop;
    logic                   w_can_start;

    // The counter is zeroed during LOAD so the start bit gets a full period.
    assign w_baud_clr = (r_state == ST_LOAD);
    assign w_baud_en  = (r_state == ST_START) || (r_state == ST_DATA) ||
                        (r_state == ST_PARITY) || (r_state == ST_STOP);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (w_baud_clr),
        .en      (w_baud_en),
        .tick    (w_tick)
    );

    assign w_can_start = tx_en_i && !fifo_empty_i;
    assign w_last_stop = w_tick && ((STOP_BITS == 1) || r_stop_idx);

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        unique case (r_state)
            ST_IDLE:   if (w_can_start) w_state_next = ST_POP;
            ST_POP:    w_state_next = ST_LOAD;
            ST_LOAD: begin
                w_state_next = ST_START;
                w_shift_next = fifo_rdata_i;
            end
            ST_START:  if (w_tick) w_state_next = ST_DATA;
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: if (w_tick) w_state_next = ST_STOP;
            ST_STOP: begin
                if (w_last_stop) begin
                    w_state_next = w_can_start ? ST_POP : ST_IDLE;
                end
            end
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Line value is derived from the next state so tx_o changes on the same
    // edge as the state transition and comes straight from a flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = r_parity;
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bit_idx  <= 3'd0;
            r_parity   <= 1'b0;
            r_stop_idx <= 1'b0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_bit_idx <= 3'd0;
                r_parity  <= calc_parity(fifo_rdata_i, (PARITY_ODD != 0));
            end else if ((r_state == ST_DATA) && w_tick) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (r_state != ST_STOP) begin
                r_stop_idx <= 1'b0;
            end else if (w_tick) begin
                r_stop_idx <= ~r_stop_idx;
            end
        end
    end

    assign fifo_rd_en_o = (r_state == ST_POP);
    assign busy_o       = (r_state != ST_IDLE);
    assign tx_o         = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx. Three instances with
//               CLKS_PER_BIT=4 share stimulus:
//                 cfg0: no parity, 1 stop   (40-cycle frame)
//                 cfg1: even parity, 1 stop (44-cycle frame)
//                 cfg2: odd parity, 2 stops (48-cycle frame)
//               Each has a FIFO model, an expected-byte queue and a line
//               monitor that decodes frames and compares against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int         CPB   = 4;
    localparam int         NCFG  = 3;
    localparam logic [2:0] PE_V  = 3'b110;
    localparam logic [2:0] ODD_V = 3'b100;
    localparam logic [2:0] ST2_V = 3'b100;

    logic            clk;
    logic            rst_n;
    logic            tx_en;
    logic            push_v;
    logic [7:0]      push_d;
    logic [NCFG-1:0] w_tx;
    logic [NCFG-1:0] w_rd;
    logic [NCFG-1:0] w_busy;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_pushed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int cfg,
                       input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cfg %0d) at %0t: got 0x%0h, expected 0x%0h",
                     name, cfg, $time, got, exp);
        end
    endtask

    generate
        for (genvar i = 0; i < NCFG; i++) begin : g_cfg
            localparam int   PE    = PE_V[i]  ? 1 : 0;
            localparam logic ODDB  = ODD_V[i];
            localparam int   NSTOP = ST2_V[i] ? 2 : 1;
            localparam int   NB    = 1 + 8 + PE + NSTOP;

            logic [7:0] q[$];
            logic [7:0] exp_q[$];
            logic [7:0] r_rdata  = 8'h00;
            logic       r_empty  = 1'b1;
            int         r_level  = 0;
            int         pop_cnt  = 0;
            int         n_rx     = 0;
            int         last_gap = -1;

            fifo_uart_tx #(
                .CLKS_PER_BIT (CPB),
                .PARITY_EN    (PE),
                .PARITY_ODD   (ODD_V[i] ? 1 : 0),
                .STOP_BITS    (NSTOP)
            ) u_dut (
                .clk_i        (clk),
                .rst_n_i      (rst_n),
                .fifo_rdata_i (r_rdata),
                .fifo_empty_i (r_empty),
                .fifo_rd_en_o (w_rd[i]),
                .tx_en_i      (tx_en),
                .tx_o         (w_tx[i]),
                .busy_o       (w_busy[i])
            );

            // FIFO model: read data valid the cycle after a pop.
            always @(posedge clk) begin
                if (w_rd[i] && (q.size() > 0)) begin
                    r_rdata <= q.pop_front();
                end
                if (w_rd[i]) pop_cnt <= pop_cnt + 1;
                if (push_v) begin
                    q.push_back(push_d);
                    exp_q.push_back(push_d);
                end
                r_empty <= (q.size() == 0);
                r_level <= q.size();
            end

            // Popping while the FIFO reports empty is never allowed.
            initial begin : g_popchk
                forever begin
                    @(posedge clk);
                    if (w_rd[i]) chk("pop_while_empty", i, r_empty, 0);
                end
            end

            // Line monitor: decode each frame cycle by cycle.
            initial begin : g_mon
                int         since_end;
                logic [7:0] exp_b;
                logic [11:0] fr;
                logic [7:0] got_b;
                logic       got_par;
                bit         bad;
                bit         aborted;
                since_end = -1000;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        since_end = -1000;
                    end else if (w_tx[i] !== 1'b0) begin
                        since_end++;
                    end else begin
                        last_gap = since_end;
                        if (exp_q.size() == 0) begin
                            chk("spurious_frame", i, 1, 0);
                            exp_b = 8'h00;
                        end else begin
                            exp_b = exp_q[0];
                        end
                        fr        = '1;
                        fr[0]     = 1'b0;
                        fr[8:1]   = exp_b;
                        if (PE != 0) fr[9] = (^exp_b) ^ ODDB;
                        bad = 0; aborted = 0; got_b = 8'h00; got_par = 1'b0;
                        for (int j = 0; j < NB * CPB; j++) begin
                            if (j > 0) @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1;
                                break;
                            end
                            if ((w_tx[i] !== fr[j / CPB]) || (w_busy[i] !== 1'b1)) bad = 1;
                            if ((j % CPB) == CPB / 2) begin
                                if ((j / CPB >= 1) && (j / CPB <= 8)) got_b[j / CPB - 1] = w_tx[i];
                                if (j / CPB == 9) got_par = w_tx[i];
                            end
                        end
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                        n_rx++;
                        if (aborted) begin
                            since_end = -1000;
                        end else begin
                            chk("rx_byte", i, got_b, exp_b);
                            if (PE != 0) chk("rx_parity", i, got_par, (^exp_b) ^ ODDB);
                            chk("frame_shape", i, bad, 0);
                            since_end = 0;
                        end
                    end
                end
            end
        end
    endgenerate

    // what: 0 pops, 1 fifo level, 2 frames seen, 3 last inter-frame gap
    function automatic int probe(input int k, input int what);
        int r;
        r = 0;
        case (k)
            0: r = (what == 0) ? g_cfg[0].pop_cnt : (what == 1) ? g_cfg[0].r_level :
                   (what == 2) ? g_cfg[0].n_rx : g_cfg[0].last_gap;
            1: r = (what == 0) ? g_cfg[1].pop_cnt : (what == 1) ? g_cfg[1].r_level :
                   (what == 2) ? g_cfg[1].n_rx : g_cfg[1].last_gap;
            default: r = (what == 0) ? g_cfg[2].pop_cnt : (what == 1) ? g_cfg[2].r_level :
                   (what == 2) ? g_cfg[2].n_rx : g_cfg[2].last_gap;
        endcase
        return r;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        push_d = b;
        push_v = 1'b1;
        n_pushed++;
        @(negedge clk);
        push_v = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (!((w_busy == '0) && (probe(0, 1) == 0) && (probe(1, 1) == 0) &&
                 (probe(2, 1) == 0)) && (t < 5000)) begin
            @(negedge clk);
            t++;
        end
        chk(name, -1, (t < 5000), 1);
    endtask

    initial begin : g_wdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : g_main
        int t;
        rst_n  = 1'b0;
        tx_en  = 1'b0;
        push_v = 1'b0;
        push_d = 8'h00;

        // Reset state, then idle with an empty FIFO.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", -1, {w_tx, w_rd, w_busy}, {3'b111, 6'b0});
        end
        rst_n = 1'b1;
        tx_en = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("idle_outputs", -1, {w_tx, w_rd, w_busy}, {3'b111, 6'b0});
        end

        // Single byte: start latency and pop pulse.
        push_byte(8'hA5);
        @(negedge clk);
        chk("pop_pulse", -1, {w_rd, w_busy}, 6'b111111);
        @(negedge clk);
        chk("load_cycle", -1, {w_rd, w_tx, w_busy}, {3'b000, 3'b111, 3'b111});
        @(negedge clk);
        chk("start_edge", -1, w_tx, 3'b000);
        wait_drain("drain_a5");
        for (int k = 0; k < NCFG; k++) chk("pops_a5", k, probe(k, 0), n_pushed);

        // Three queued bytes back-to-back, then the parity byte.
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        wait_drain("drain_three");
        for (int k = 0; k < NCFG; k++) begin
            chk("pops_three", k, probe(k, 0), n_pushed);
            chk("b2b_gap", k, probe(k, 3), 2);
        end
        push_byte(8'h07);
        wait_drain("drain_07");

        // tx_en low: queued bytes must not be popped.
        tx_en = 1'b0;
        for (int n = 0; n < 3; n++) push_byte(8'($urandom));
        repeat (20) @(negedge clk);
        for (int k = 0; k < NCFG; k++) chk("no_pop_disabled", k, probe(k, 0), n_pushed - 3);
        chk("idle_disabled", -1, w_busy, 3'b000);

        // Enable, then drop tx_en during data bit 2 of the first frame.
        tx_en = 1'b1;
        repeat (16) @(negedge clk);
        chk("mid_frame_busy", -1, w_busy, 3'b111);
        tx_en = 1'b0;
        t = 0;
        while ((w_busy != '0) && (t < 200)) begin
            @(negedge clk);
            t++;
        end
        chk("frame_finish_timeout", -1, (t < 200), 1);
        repeat (20) @(negedge clk);
        for (int k = 0; k < NCFG; k++) begin
            chk("single_pop_after_drop", k, probe(k, 0), n_pushed - 2);
            chk("fifo_left", k, probe(k, 1), 2);
        end
        chk("idle_after_drop", -1, w_busy, 3'b000);
        tx_en = 1'b1;
        wait_drain("drain_reenable");

        // Random bytes with random spacing.
        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            push_byte(8'($urandom));
        end
        wait_drain("drain_random");

        // Reset during data bit 3: frame aborted, next byte still sent intact.
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((w_tx[0] !== 1'b0) && (t < 20));
        chk("start_before_reset", -1, (t < 20), 1);
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", -1, {w_tx, w_rd, w_busy}, {3'b111, 6'b0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_drain("drain_after_reset");

        for (int k = 0; k < NCFG; k++) begin
            chk("total_pops", k, probe(k, 0), n_pushed);
            chk("total_frames", k, probe(k, 2), n_pushed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
